// File: rtl/idex_pipe_reg.sv
// idex_pipe_reg: ID/EX pipeline register with a valid/ready handshake and a one-entry skid buffer.
//   It also supports a synchronous flush, an optional effective-address pre-add and a saturating stall counter.
// Ports:
//   clk, rst_n (async, active-low), flush (sync bubble insert)
//   in_valid/in_ready + rd1_in, rd2_in, imm_in, opcode_in, funct_in, rs_in, rt_in, addr_in, ctrl_in : decode side
//   out_valid/out_ready + matching *_out fields : execute side, driven from the main register
//   stall_cnt : count of cycles with out_valid=1 and out_ready=0, saturating
module idex_pipe_reg #(
    parameter int DATA_W  = 16,
    parameter int REG_W   = 4,
    parameter int OP_W    = 4,
    parameter int ADDR_W  = 8,
    parameter int EA_MODE = 1,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] rd1_in,
    input  logic [DATA_W-1:0] rd2_in,
    input  logic [DATA_W-1:0] imm_in,
    input  logic [OP_W-1:0]   opcode_in,
    input  logic [OP_W-1:0]   funct_in,
    input  logic [REG_W-1:0]  rs_in,
    input  logic [REG_W-1:0]  rt_in,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [8:0]        ctrl_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] rd1_out,
    output logic [DATA_W-1:0] rd2_out,
    output logic [DATA_W-1:0] imm_out,
    output logic [OP_W-1:0]   opcode_out,
    output logic [OP_W-1:0]   funct_out,
    output logic [REG_W-1:0]  rs_out,
    output logic [REG_W-1:0]  rt_out,
    output logic [ADDR_W-1:0] addr_out,
    output logic [8:0]        ctrl_out,
    output logic [CNT_W-1:0]  stall_cnt
);
    localparam int BW = 3*DATA_W + 2*OP_W + 2*REG_W + ADDR_W + 9;
    logic [BW-1:0]     in_b, m_b, s_b;
    logic [DATA_W-1:0] imm_x;
    logic [8:0]        ctrl_m;
    logic              m_valid, s_valid, accept, m_free;
    // ALUSrc set: pre-add base register so execute sees the effective address
    assign imm_x    = (EA_MODE != 0 && ctrl_in[7]) ? imm_in + rd2_in : imm_in;
    assign in_b     = {ctrl_in, addr_in, rt_in, rs_in, funct_in, opcode_in, imm_x, rd2_in, rd1_in};
    assign in_ready = !s_valid;
    assign accept   = in_valid && in_ready;
    assign m_free   = !m_valid || out_ready;
    assign out_valid = m_valid;
    assign {ctrl_m, addr_out, rt_out, rs_out, funct_out, opcode_out, imm_out, rd2_out, rd1_out} = m_b;
    assign ctrl_out = m_valid ? ctrl_m : '0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_b       <= '0;
            s_b       <= '0;
            m_valid   <= 1'b0;
            s_valid   <= 1'b0;
            stall_cnt <= '0;
        end else if (flush) begin
            m_b     <= '0;
            m_valid <= 1'b0;
            s_valid <= 1'b0;
        end else begin
            if (m_free) begin
                // skid entry always drains first to keep order; accept is impossible while it is full
                if (s_valid) begin
                    m_b     <= s_b;
                    m_valid <= 1'b1;
                    s_valid <= 1'b0;
                end else if (accept) begin
                    m_b     <= in_b;
                    m_valid <= 1'b1;
                end else begin
                    m_valid <= 1'b0;
                end
            end else if (accept) begin
                s_b     <= in_b;
                s_valid <= 1'b1;
            end
            if (m_valid && !out_ready && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_idex_pipe_reg.sv
// tb_idex_pipe_reg: directed self-checking bench for idex_pipe_reg (EA/16-bit counter and no-EA/4-bit counter instances).
module tb_idex_pipe_reg;
    logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [15:0] rd1_in = '0, rd2_in = '0, imm_in = '0;
    logic [3:0]  opcode_in = '0, funct_in = '0, rs_in = '0, rt_in = '0;
    logic [7:0]  addr_in = '0;
    logic [8:0]  ctrl_in = '0;
    logic        in_ready, out_valid;
    logic [15:0] rd1_out, rd2_out, imm_out, stall_cnt;
    logic [3:0]  opcode_out, funct_out, rs_out, rt_out;
    logic [7:0]  addr_out;
    logic [8:0]  ctrl_out;
    logic        b_in_ready, b_out_valid;
    logic [15:0] b_rd1, b_rd2, b_imm;
    logic [3:0]  b_opcode, b_funct, b_rs, b_rt, b_stall;
    logic [7:0]  b_addr;
    logic [8:0]  b_ctrl;
    int n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    idex_pipe_reg dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .rd1_in(rd1_in), .rd2_in(rd2_in), .imm_in(imm_in), .opcode_in(opcode_in), .funct_in(funct_in),
        .rs_in(rs_in), .rt_in(rt_in), .addr_in(addr_in), .ctrl_in(ctrl_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .rd1_out(rd1_out), .rd2_out(rd2_out), .imm_out(imm_out), .opcode_out(opcode_out), .funct_out(funct_out),
        .rs_out(rs_out), .rt_out(rt_out), .addr_out(addr_out), .ctrl_out(ctrl_out), .stall_cnt(stall_cnt)
    );

    idex_pipe_reg #(.EA_MODE(0), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
        .rd1_in(rd1_in), .rd2_in(rd2_in), .imm_in(imm_in), .opcode_in(opcode_in), .funct_in(funct_in),
        .rs_in(rs_in), .rt_in(rt_in), .addr_in(addr_in), .ctrl_in(ctrl_in),
        .out_valid(b_out_valid), .out_ready(out_ready),
        .rd1_out(b_rd1), .rd2_out(b_rd2), .imm_out(b_imm), .opcode_out(b_opcode), .funct_out(b_funct),
        .rs_out(b_rs), .rt_out(b_rt), .addr_out(b_addr), .ctrl_out(b_ctrl), .stall_cnt(b_stall)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [15:0] rd1, input logic [15:0] rd2, input logic [15:0] imm, input logic [8:0] ctrl);
        in_valid = 1'b1;
        rd1_in = rd1;
        rd2_in = rd2;
        imm_in = imm;
        ctrl_in = ctrl;
    endtask

    initial begin
        #3;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_ctrl", 32'(ctrl_out), 0);
        chk("rst_stall", 32'(stall_cnt), 0);
        chk("rst_rd1", 32'(rd1_out), 0);
        #9 rst_n = 1'b1;
        // single bundle with EA pre-add
        out_ready = 1'b1;
        offer(16'h1234, 16'h0010, 16'h0005, 9'h0A0);
        opcode_in = 4'h3; funct_in = 4'h5; rs_in = 4'h1; rt_in = 4'h2; addr_in = 8'h40;
        tick();
        chk("one_valid", 32'(out_valid), 1);
        chk("one_imm_ea", 32'(imm_out), 32'h0015);
        chk("one_imm_noea", 32'(b_imm), 32'h0005);
        chk("one_ctrl", 32'(ctrl_out), 32'h0A0);
        chk("one_rd1", 32'(rd1_out), 32'h1234);
        chk("one_addr", 32'(addr_out), 32'h40);
        chk("one_tags", 32'({opcode_out, funct_out, rs_out, rt_out}), 32'h3512);
        in_valid = 1'b0;
        tick();
        chk("one_drain_valid", 32'(out_valid), 0);
        chk("one_drain_ctrl", 32'(ctrl_out), 0);
        // back-to-back stream of 8
        for (int i = 0; i < 8; i++) begin
            offer(16'(16'h0100 + i), 16'h0, 16'h0, 9'h020);
            chk($sformatf("stream_in_ready%0d", i), 32'(in_ready), 1);
            tick();
            chk($sformatf("stream_valid%0d", i), 32'(out_valid), 1);
            chk($sformatf("stream_rd1_%0d", i), 32'(rd1_out), 32'h0100 + i);
        end
        in_valid = 1'b0;
        tick();
        chk("stream_end_valid", 32'(out_valid), 0);
        chk("stream_stall", 32'(stall_cnt), 0);
        // stall with A,B,C
        out_ready = 1'b0;
        offer(16'h00A1, 16'h0, 16'h0, 9'h020);
        tick();
        chk("stall_a_valid", 32'(out_valid), 1);
        offer(16'h00B2, 16'h0, 16'h0, 9'h020);
        chk("stall_b_ready", 32'(in_ready), 1);
        tick();
        chk("stall_ready_low", 32'(in_ready), 0);
        chk("stall_m_a", 32'(rd1_out), 32'h00A1);
        offer(16'h00C3, 16'h0, 16'h0, 9'h020);
        tick();
        tick();
        chk("stall_ready_low2", 32'(in_ready), 0);
        chk("stall_hold_a", 32'(rd1_out), 32'h00A1);
        chk("stall_cnt3", 32'(stall_cnt), 3);
        out_ready = 1'b1;
        tick();
        chk("release_b", 32'(rd1_out), 32'h00B2);
        chk("release_ready", 32'(in_ready), 1);
        tick();
        chk("release_c", 32'(rd1_out), 32'h00C3);
        in_valid = 1'b0;
        tick();
        chk("release_empty", 32'(out_valid), 0);
        chk("release_stall", 32'(stall_cnt), 3);
        // flush with A in M, B in S, C offered
        out_ready = 1'b0;
        offer(16'h0A0A, 16'h0, 16'h0, 9'h0A0);
        tick();
        offer(16'h0B0B, 16'h0, 16'h0, 9'h0A0);
        tick();
        chk("pre_flush_stall", 32'(stall_cnt), 4);
        offer(16'h0C0C, 16'h0, 16'h0, 9'h0A0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_valid", 32'(out_valid), 0);
        chk("flush_ctrl", 32'(ctrl_out), 0);
        chk("flush_ready", 32'(in_ready), 1);
        chk("flush_stall", 32'(stall_cnt), 4);
        chk("flush_rd1", 32'(rd1_out), 0);
        tick();
        chk("flush_c_gone", 32'(out_valid), 0);
        // EA overflow
        out_ready = 1'b1;
        offer(16'h0000, 16'hFFFF, 16'h0002, 9'h080);
        tick();
        chk("ovf_imm", 32'(imm_out), 32'h0001);
        chk("ovf_imm_noea", 32'(b_imm), 32'h0002);
        // 20 stall cycles; first one also pushes a bundle into S
        out_ready = 1'b0;
        offer(16'h0D0D, 16'h0, 16'h0, 9'h020);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 19; i++) tick();
        chk("sat_stall16", 32'(stall_cnt), 24);
        chk("sat_stall4", 32'(b_stall), 15);
        chk("sat_ready_low", 32'(in_ready), 0);
        // async reset between edges
        #3 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 0);
        chk("arst_ctrl", 32'(ctrl_out), 0);
        chk("arst_stall", 32'(stall_cnt), 0);
        chk("arst_stall_b", 32'(b_stall), 0);
        chk("arst_ready", 32'(in_ready), 1);
        #2 rst_n = 1'b1;
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
